// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for a radix-2 shift-add multiply in EX; stalls the pipeline until done.
// Optional macro MUL_SEQ_EARLY_TERM_EN ends the multiply as soon as the multiplier runs out of set bits.
module mul_seq_ctrl #(
  parameter int          WIDTH    = 32,
  parameter logic [3:0]  MUL_CODE = 4'b0011,
  parameter int          CNT_W    = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic             ex_valid_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  prod_q, prod_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic              start;
  logic [WIDTH-1:0]  prod_sum;
  logic [WIDTH-1:0]  mplier_shr;
  logic              last_iter;

  // Handshake: stall_o rises in the same cycle a MUL is accepted and stays high
  // while BUSY; the cycle it drops (DONE) is the one where done_o/result_o are consumed.
  assign start      = ex_valid_i & (alu_ctrl_i == MUL_CODE) & ~flush_i;
  assign prod_sum   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mplier_shr = mplier_q >> 1;
`ifdef MUL_SEQ_EARLY_TERM_EN
  assign last_iter  = (cnt_q == CNT_W'(WIDTH - 1)) | (mplier_shr == '0);
`else
  assign last_iter  = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    result_d = result_q;
    stall_o  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          stall_o  = 1'b1;
          mcand_d  = src1_i;
          mplier_d = src2_i;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = BUSY;
`ifdef MUL_SEQ_EARLY_TERM_EN
          if (src2_i == '0) begin
            state_d  = DONE;
            result_d = '0;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          // Abort: partial product is dropped and result_o keeps the last good value.
          state_d = IDLE;
          cnt_d   = '0;
          prod_d  = '0;
        end else begin
          prod_d   = prod_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_shr;
          cnt_d    = cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_d  = DONE;
            result_d = prod_sum;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = (state_q == BUSY);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: latency, stall window, results, flush, reset and back-to-back MULs.
// Expected latencies follow MUL_SEQ_EARLY_TERM_EN when the bench is built with that macro.
module tb_mul_seq_ctrl;

  localparam int         W   = 32;
  localparam logic [3:0] MUL = 4'b0011;
`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // clock / reset
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   alu_ctrl = 4'b0000;
  logic         ex_valid = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         stall_o, busy_o, done_o;
  logic [W-1:0] result_o;
  logic [1:0]   state_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(W), .MUL_CODE(MUL), .CNT_W(6)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .alu_ctrl_i (alu_ctrl),
    .ex_valid_i (ex_valid),
    .flush_i    (flush),
    .src1_i     (src1),
    .src2_i     (src2),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .state_o    (state_o)
  );

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int full, input int early);
    return EARLY ? early : full;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mul(input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = MUL;
    ex_valid = 1'b1;
    src1     = a;
    src2     = b;
  endtask

  task automatic drive_idle();
    alu_ctrl = 4'b0000;
    ex_valid = 1'b0;
    src1     = 32'hDEAD_BEEF;
    src2     = 32'h1234_5677;
  endtask

  // Starts one MUL, then tracks stall/busy/done for a bounded window.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
    int stall_cnt, busy_cnt, done_cnt, done_at;
    stall_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    tick();
    drive_mul(a, b);
    for (int c = 0; c < lat + 4; c++) begin
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (busy_o)  busy_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          check_eq({tag, "_result"}, result_o, exp);
        end
      end
      tick();
      if (c == 0) drive_idle();
    end
    check_eq({tag, "_done_at"},  done_at,   lat);
    check_eq({tag, "_done_cnt"}, done_cnt,  1);
    check_eq({tag, "_stall_cnt"}, stall_cnt, lat);
    check_eq({tag, "_busy_cnt"},  busy_cnt,  lat - 1);
    check_eq({tag, "_held"},      result_o,  exp);
  endtask

  logic [3:0] other_codes [4] = '{4'b0000, 4'b0010, 4'b0111, 4'b1011};

  initial begin
    int f_at, r_at, lat1, lat2, done_at, done_cnt;

    // reset state
    drive_idle();
    #2;
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_result", result_o, 0);
    check_eq("rst_state", state_o, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // basic
    run_mul("mul7x6", 32'd7, 32'd6, 32'd42, pick(33, 4));

    // flush mid-BUSY: result keeps 42, no done pulse
    f_at = pick(5, 2);
    tick();
    drive_mul(32'd9, 32'd9);
    for (int c = 1; c <= f_at; c++) begin
      tick();
      drive_idle();
      if (c == f_at) flush = 1'b1;
    end
    @(negedge clk);
    check_eq("flush_stall_same", stall_o, 1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_stall_next", stall_o, 0);
    check_eq("flush_busy_next", busy_o, 0);
    check_eq("flush_state", state_o, 0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) done_cnt++;
    end
    check_eq("flush_no_done", done_cnt, 0);
    check_eq("flush_result", result_o, 32'd42);

    // asynchronous reset mid-BUSY
    r_at = pick(10, 2);
    tick();
    drive_mul(32'd7, 32'd6);
    for (int c = 1; c <= r_at; c++) begin
      tick();
      drive_idle();
    end
    rst_n = 1'b0;
    #1;
    check_eq("arst_stall", stall_o, 0);
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_result", result_o, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_state", state_o, 0);
    check_eq("arst_busy_after", busy_o, 0);

    // signed wrap and overflow
    run_mul("neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, pick(33, 4));
    run_mul("ovf", 32'h0001_0000, 32'h0001_0000, 32'h0, pick(33, 18));

    // back-to-back: 4*5 presented in the DONE cycle of 2*3
    lat1 = pick(33, 3);
    lat2 = pick(33, 4);
    tick();
    drive_mul(32'd2, 32'd3);
    for (int c = 1; c <= lat1; c++) begin
      tick();
      if (c == lat1) drive_mul(32'd4, 32'd5);
      else drive_idle();
    end
    @(negedge clk);
    check_eq("b2b_done1", done_o, 1);
    check_eq("b2b_result1", result_o, 32'd6);
    check_eq("b2b_stall1", stall_o, 1);
    tick();
    drive_idle();
    done_at = -1;
    for (int c = 1; c <= lat2 + 3; c++) begin
      @(negedge clk);
      if (done_o && done_at < 0) begin
        done_at = c;
        check_eq("b2b_result2", result_o, 32'd20);
      end
      tick();
    end
    check_eq("b2b_done_at2", done_at, lat2);

    // early termination cases (fixed latency without the macro)
    run_mul("mul3x2", 32'd3, 32'd2, 32'd6, pick(33, 3));
    run_mul("mul5x0", 32'd5, 32'd0, 32'd0, pick(33, 1));

    // MUL with flush while IDLE never starts
    tick();
    drive_mul(32'd6, 32'd7);
    flush = 1'b1;
    @(negedge clk);
    check_eq("idle_flush_stall", stall_o, 0);
    tick();
    drive_idle();
    flush = 1'b0;
    @(negedge clk);
    check_eq("idle_flush_busy", busy_o, 0);
    check_eq("idle_flush_state", state_o, 0);

    // non-MUL codes never start
    foreach (other_codes[i]) begin
      tick();
      alu_ctrl = other_codes[i];
      ex_valid = 1'b1;
      src1 = 32'd3;
      src2 = 32'd3;
      @(negedge clk);
      check_eq($sformatf("code%0h_stall", other_codes[i]), stall_o, 0);
      tick();
      drive_idle();
      @(negedge clk);
      check_eq($sformatf("code%0h_busy", other_codes[i]), busy_o, 0);
    end
    check_eq("final_result", result_o, 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencing controller for a multi-cycle iterative (shift-add) multiply in the EX stage.
- Detects a MUL ALU control code, freezes the pipeline with a stall request, and runs a radix-2 multiply over WIDTH cycles.
- Presents the low WIDTH bits of the product with a one-cycle done pulse.
- Sits beside the ALU. The EX-stage result mux selects result_o when done_o is high.

Parameters:
- WIDTH, 32, operand/result width in bits.
- MUL_CODE, 4'b0011, ALU control code that starts a multiply.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- alu_ctrl_i  input  4  ALU control code of the instruction in EX.
- ex_valid_i  input  1  EX stage holds a valid instruction.
- flush_i  input  1  EX flush (branch/exception); aborts any multiply.
- src1_i  input  WIDTH  multiplicand (rs).
- src2_i  input  WIDTH  multiplier (rt).
- stall_o  output  1  freeze PC and IF/ID, ID/EX registers.
- busy_o  output  1  FSM in BUSY.
- done_o  output  1  one-cycle pulse: result_o valid.
- result_o  output  WIDTH  low WIDTH bits of src1*src2. Two's-complement, so identical for signed and unsigned.

Behaviour:
- Reset (rst_i=0, asynchronous, any state): state=IDLE, counter=0, product=0, multiplicand/multiplier regs=0. Outputs: stall_o=0, busy_o=0, done_o=0, result_o=0.
- start = ex_valid_i & (alu_ctrl_i==MUL_CODE) & ~flush_i, evaluated in IDLE or DONE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On start: latch mcand=src1_i, mplier=src2_i; clear product and counter; go to BUSY.
  - Otherwise: stay in IDLE.
- BUSY, one iteration per cycle:
  - If mplier[0]=1, product += mcand (mod 2^WIDTH).
  - Then mcand <<= 1, mplier >>= 1 (logical shift), counter += 1.
  - When counter==WIDTH-1 in the current cycle, go to DONE.
- DONE:
  - done_o=1 for exactly this cycle; result_o=product.
  - If start holds (a back-to-back MUL has entered EX): relatch operands, go to BUSY.
  - Otherwise: go to IDLE.
- stall_o is combinational: stall_o = (start in IDLE/DONE) | (state==BUSY). It is low in DONE unless a new start occurs.
- Latency: start sampled at cycle T. BUSY covers T+1..T+WIDTH. DONE occurs at T+WIDTH+1. stall_o is high for WIDTH+1 cycles (T..T+WIDTH).
- result_o holds its last value until the next DONE. The register updates only on entry to DONE.
- busy_o = (state==BUSY).
- Flush:
  - flush_i=1 in BUSY: next state IDLE; counter cleared; product discarded; result_o unchanged; no done pulse. stall_o stays high in that cycle, low from the next cycle.
  - flush_i=1 with a MUL in IDLE: no start, stall_o=0.
- Operand changes on src1_i/src2_i during BUSY are ignored, since the operands are latched.
- alu_ctrl_i values other than MUL_CODE never start the FSM; stall_o stays 0.
- Overflow: upper product bits are discarded with no flag.

Optional Feature:
- Macro: MUL_SEQ_EARLY_TERM_EN.
- When defined, early termination is enabled:
  - In BUSY, go to DONE after the iteration where the shifted mplier becomes 0, even if counter<WIDTH-1.
  - At start, if src2_i==0, go directly to DONE with product=0. DONE then occurs at T+1 and stall_o is high only at T.
- When not defined: always exactly WIDTH iterations; latency is fixed as stated in Behaviour.

Test Plan:
- Reset mid-BUSY: start 7*6, assert rst_i=0 at T+10 -> immediately stall_o=0, busy_o=0, result_o=0. After release, state is IDLE.
- Basic: at T, alu_ctrl_i=4'b0011, ex_valid_i=1, src1=7, src2=6 -> stall_o high T..T+32, done_o=1 and result_o=42 at T+33, stall_o=0 at T+33.
- Signed/wrap: src1=32'hFFFFFFFD (-3), src2=5 -> result_o=32'hFFFFFFF1. Then src1=src2=32'h00010000 -> result_o=0 (overflow discarded).
- Flush: start 9*9, flush_i=1 at T+5 -> stall_o=0 from T+6, no done_o pulse, result_o keeps its previous value, FSM in IDLE.
- Back-to-back: in the DONE cycle of 2*3 (result_o=6), present MUL 4*5 -> stall_o=1 in that cycle; next done_o delivers 20, WIDTH+1 cycles later.
- Early termination (MUL_SEQ_EARLY_TERM_EN defined):
  - 3*2 -> done_o at T+3 with result 6.
  - 5*0 -> done_o at T+1 with result 0.
  - Without the macro, both cases complete at T+33.
